// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush controller for the 5-stage pipeline.
// Merges data-memory wait, MUL/DIV occupancy, branch redirect and load-use
// hazards into per-stage write enables and bubble/flush controls.
// Handshake note: mdu_done is a one-cycle pulse with no ready; if it lands
// while the pipeline is frozen it is latched in done_seen so it is never lost.
module hazard_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_rs1_used,
  input  logic             if_id_rs2_used,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             mdu_error,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  localparam int TMO_W = $clog2(MDU_TIMEOUT + 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             done_seen;

  logic freeze;
  logic mdu_busy;
  logic load_use;
  logic mdu_release;

  assign state_dbg = state;

  // Hazard detection terms shared by output decode and state update
  always_comb begin
    freeze   = dmem_req & ~dmem_ready;
    mdu_busy = 1'b0;
    if (state == RUN)
      mdu_busy = ex_mdu_start & ~mdu_done;
    else if (state == MDU_WAIT)
      mdu_busy = ~mdu_done & ~done_seen;
    load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
               ((if_id_rs1_used && (if_id_rs1 == id_ex_rd)) ||
                (if_id_rs2_used && (if_id_rs2 == id_ex_rd)));
    mdu_release = (mdu_done | done_seen) & ~freeze;
  end

  // Priority decode: freeze > MDU occupancy > branch > load-use > default
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if (state == INIT) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (freeze) begin
      // Branch flush is suppressed too; the branch stays in EX and retries
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mdu_busy) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // ID instruction is flushed, so any load-use match is irrelevant
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // FSM, MDU timeout tracking, done latch and stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      tmo_cnt     <= '0;
      done_seen   <= 1'b0;
      mdu_error   <= 1'b0;
      stall_count <= '0;
    end else begin
      if (state != INIT && !pc_write && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (ex_mdu_start && !mdu_done) begin
            state     <= MDU_WAIT;
            tmo_cnt   <= '0;
            done_seen <= 1'b0;
          end
        end
        MDU_WAIT: begin
          if (tmo_cnt != TMO_W'(MDU_TIMEOUT))
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (tmo_cnt == TMO_W'(MDU_TIMEOUT - 1))
            mdu_error <= 1'b1;
          if (mdu_release) begin
            state     <= RUN;
            done_seen <= 1'b0;
          end else if (mdu_done && freeze) begin
            done_seen <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_sequencer;

  localparam int CNT_W = 16;
  localparam int TMO   = 64;
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic clk, rst_n;
  logic id_ex_memread, if_id_rs1_used, if_id_rs2_used;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic ex_branch_taken, ex_mdu_start, mdu_done, dmem_req, dmem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
  logic [CNT_W-1:0] stall_count;
  logic mdu_error;
  logic [1:0] state_dbg;

  hazard_sequencer #(.CNT_W(CNT_W), .MDU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .stall_count(stall_count), .mdu_error(mdu_error), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_ctrl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] ctrl_now();
    return {pc_write, if_id_write, id_ex_write, ex_mem_write,
            if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble};
  endfunction

  // ---------------- reference model ----------------
  // Pipeline view: "waiting" means an MDU op is parked in EX.
  bit m_init, m_wait, m_seen, m_err;
  int m_tmo, m_stall;

  task automatic model_reset();
    m_init = 1; m_wait = 0; m_seen = 0; m_err = 0; m_tmo = 0; m_stall = 0;
  endtask

  function automatic logic [7:0] model_ctrl();
    bit frz, busy, lu;
    frz  = dmem_req && !dmem_ready;
    busy = m_wait ? !(mdu_done || m_seen) : (ex_mdu_start && !mdu_done);
    lu   = id_ex_memread && id_ex_rd != 0 &&
           ((if_id_rs1_used && if_id_rs1 == id_ex_rd) ||
            (if_id_rs2_used && if_id_rs2 == id_ex_rd));
    if (m_init)          return 8'b0000_0000;
    if (frz)             return 8'b0000_0001;
    if (busy)            return 8'b0001_0010;
    if (ex_branch_taken) return 8'b1111_1100;
    if (lu)              return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  task automatic model_clock(input logic [7:0] ctl);
    bit frz;
    frz = dmem_req && !dmem_ready;
    if (m_init) begin
      m_init = 0;
      return;
    end
    if (!ctl[7] && m_stall < 65535) m_stall++;
    if (!m_wait) begin
      if (ex_mdu_start && !mdu_done) begin
        m_wait = 1; m_tmo = 0; m_seen = 0;
      end
    end else begin
      m_tmo++;
      if (m_tmo >= TMO) m_err = 1;
      if ((mdu_done || m_seen) && !frz) begin
        m_wait = 0; m_seen = 0;
      end else if (mdu_done && frz) begin
        m_seen = 1;
      end
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_init) return S_INIT;
    return m_wait ? S_WAIT : S_RUN;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_ex_memread = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    if_id_rs1_used = 0; if_id_rs2_used = 0; ex_branch_taken = 0;
    ex_mdu_start = 0; mdu_done = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // Called at posedge+1 with inputs set; compares mid-cycle, then clocks.
  task automatic step();
    logic [7:0] e;
    #3;
    e = model_ctrl();
    exp_q.push_back(e);
    obs_ctrl = ctrl_now();
    check("ctrl", obs_ctrl, exp_q.pop_front());
    check("stall_count", stall_count, m_stall);
    check("mdu_error", mdu_error, m_err);
    check("state", state_dbg, model_state());
    @(posedge clk);
    model_clock(e);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    check("rst_ctrl", ctrl_now(), 8'h00);
    check("rst_cnt", stall_count, 0);
    check("rst_err", mdu_error, 0);
    check("rst_state", state_dbg, S_INIT);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_a, cnt_b;
    idle();
    rst_n = 1;
    #3;
    do_reset();
    step();                                   // INIT cycle
    check("run_after_init", state_dbg, S_RUN);

    // Load-use on rs2
    id_ex_memread = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_rs2_used = 1;
    step();
    check("lu_stall", obs_ctrl, 8'b0011_0100);
    idle(); step();
    check("lu_resume", obs_ctrl, 8'b1111_0000);
    check("lu_count", stall_count, 1);

    // Load to x0, and match with rs1 not used
    id_ex_memread = 1; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs1_used = 1;
    step();
    check("x0_nostall", obs_ctrl[7], 1);
    id_ex_rd = 7; if_id_rs1 = 7; if_id_rs1_used = 0;
    step();
    check("unused_nostall", obs_ctrl[7], 1);

    // Load-use coinciding with branch
    if_id_rs1_used = 1; ex_branch_taken = 1;
    step();
    check("branch_wins", obs_ctrl, 8'b1111_1100);
    idle();
    check("count_after_branch", stall_count, 1);

    // MDU op, done after 10 cycles
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i <= 10; i++) begin
      ex_mdu_start = 1; mdu_done = (i == 10);
      step();
      if (!obs_ctrl[7]) cnt_a++;
      if (obs_ctrl[1]) cnt_b++;
    end
    check("mdu_stalls", cnt_a, 10);
    check("mdu_exm_bubbles", cnt_b, 10);
    check("mdu_release_pc", obs_ctrl[7], 1);
    check("mdu_state_run", state_dbg, S_RUN);
    check("mdu_count", stall_count, 11);
    idle();

    // MDU wait with freeze; done pulse lands while frozen
    ex_mdu_start = 1;
    step();
    cnt_a = 0;
    for (int j = 0; j < 3; j++) begin
      dmem_req = 1; dmem_ready = 0; mdu_done = (j == 1);
      step();
      if (obs_ctrl[0]) cnt_a++;
    end
    check("frz_mwb_bubbles", cnt_a, 3);
    dmem_req = 0; mdu_done = 0;
    step();
    check("frz_release", obs_ctrl, 8'b1111_0000);
    check("frz_state_run", state_dbg, S_RUN);
    check("frz_count", stall_count, 15);
    idle();

    // Timeout: mdu_done never arrives
    ex_mdu_start = 1;
    step();                                   // enter MDU_WAIT
    for (int k = 0; k < TMO - 1; k++) step();
    check("tmo_not_yet", mdu_error, 0);
    step();
    check("tmo_err", mdu_error, 1);
    step(); step();
    check("tmo_still_wait", state_dbg, S_WAIT);
    check("tmo_sticky", mdu_error, 1);

    // Reset mid-wait
    do_reset();
    idle();
    step();
    check("rst_run", state_dbg, S_RUN);

    // Randomized traffic
    for (int r = 0; r < 3000; r++) begin
      id_ex_memread   = ($urandom_range(0, 2) == 0);
      id_ex_rd        = 5'($urandom_range(0, 3));
      if_id_rs1       = 5'($urandom_range(0, 3));
      if_id_rs2       = 5'($urandom_range(0, 3));
      if_id_rs1_used  = $urandom_range(0, 1);
      if_id_rs2_used  = $urandom_range(0, 1);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mdu_start    = ($urandom_range(0, 7) == 0);
      mdu_done        = ($urandom_range(0, 9) == 0);
      dmem_req        = $urandom_range(0, 1);
      dmem_ready      = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Combines four hazard sources into one consistent set of per-stage write-enables and bubble/flush controls:
  - data-memory wait
  - multi-cycle MUL/DIV occupancy of EX
  - taken-branch redirect
  - load-use dependency
- Sits beside the pipeline registers and drives the PC, IF/ID, ID/EX and EX/MEM enables.
- Owns a small FSM for multi-cycle EX operations and a stall-cycle counter.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- MDU_TIMEOUT, 64, cycles spent in MDU_WAIT before mdu_error is raised.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- id_ex_memread  input  1  instruction in EX is a load
- id_ex_rd  input  5  destination register of instruction in EX
- if_id_rs1  input  5  rs1 of instruction in ID
- if_id_rs2  input  5  rs2 of instruction in ID
- if_id_rs1_used  input  1  ID instruction reads rs1
- if_id_rs2_used  input  1  ID instruction reads rs2
- ex_branch_taken  input  1  taken branch/jump resolved in EX
- ex_mdu_start  input  1  EX holds a MUL/DIV op needing the MDU
- mdu_done  input  1  MDU result valid, single-cycle pulse
- dmem_req  input  1  MEM stage has an active access
- dmem_ready  input  1  data memory completes access this cycle
- pc_write  output  1  PC register load enable
- if_id_write  output  1  IF/ID load enable
- id_ex_write  output  1  ID/EX load enable
- ex_mem_write  output  1  EX/MEM load enable
- if_id_flush  output  1  load NOP into IF/ID
- id_ex_bubble  output  1  zero ID/EX control fields on load
- ex_mem_bubble  output  1  zero EX/MEM control fields on load
- mem_wb_bubble  output  1  zero MEM/WB control fields on load
- stall_count  output  CNT_W  cycles with pc_write=0, saturating
- mdu_error  output  1  sticky MDU timeout flag

Behaviour:
- States: INIT, RUN, MDU_WAIT. Async reset enters INIT, clears stall_count, mdu_error, timeout counter and done_seen.
- INIT outputs:
  - all *_write=0, all bubbles=0, if_id_flush=0.
  - INIT lasts exactly one clock after rst_n deasserts, then goes to RUN.
  - INIT cycles are not counted in stall_count.
- Output decode in RUN/MDU_WAIT is combinational and applied in strict priority:
  - P1, freeze: dmem_req=1 and dmem_ready=0.
    - pc_write, if_id_write, id_ex_write and ex_mem_write all =0.
    - mem_wb_bubble=1.
    - All lower-priority actions are suppressed, including branch flush. The branch is held in EX and reasserts later.
  - P2, MDU occupancy: in RUN with ex_mdu_start=1, or in MDU_WAIT with mdu_done=0 and done_seen=0.
    - pc_write, if_id_write and id_ex_write =0.
    - ex_mem_write=1 and ex_mem_bubble=1.
  - P3, branch: ex_branch_taken=1.
    - pc_write=1 (loads target), if_id_flush=1, id_ex_bubble=1.
    - The load-use check is ignored because the ID instruction is flushed.
  - P4, load-use: id_ex_memread=1, id_ex_rd!=0, and either (if_id_rs1_used and if_id_rs1==id_ex_rd) or (if_id_rs2_used and if_id_rs2==id_ex_rd).
    - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1.
    - The stall lasts one cycle only; the load advances to MEM and the hazard self-clears.
  - Default: all *_write=1, all bubbles/flush=0.
- FSM transitions:
  - RUN to MDU_WAIT when ex_mdu_start=1 and mdu_done=0 (the freeze condition does not block entry). On RUN with ex_mdu_start=1 and mdu_done=1 in the same cycle: no stall from P2, stay in RUN.
  - MDU_WAIT to RUN when mdu_done or done_seen is set and freeze=0. In that release cycle P2 is inactive, so the EX instruction advances normally.
- done_seen:
  - Set when mdu_done=1 in MDU_WAIT while freeze=1, so the done pulse is never lost.
  - Cleared on exit to RUN.
- Timeout:
  - Counter resets on MDU_WAIT entry and increments each MDU_WAIT cycle, including frozen cycles.
  - On reaching MDU_TIMEOUT, mdu_error is set sticky. The state remains MDU_WAIT; only reset clears it.
- stall_count: +1 on every non-INIT cycle with pc_write=0; holds at all-ones.
- Reset asserted mid-stall: immediate return to INIT with INIT outputs; no partial state is retained.

Test Plan:
- Load x5 in EX, ID reads rs2=x5 with rs2_used=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all enables 1; stall_count=1.
- Load to x0 in EX, ID rs1=x0 -> no stall, stall_count stays 0. Repeat with rs1 match but rs1_used=0 -> no stall.
- Load-use hazard and ex_branch_taken in the same cycle -> pc_write=1, if_id_flush=1, id_ex_bubble=1, no stall.
- ex_mdu_start held, mdu_done after 10 cycles -> exactly 10 stall cycles with ex_mem_bubble=1, release on the done cycle, state RUN, stall_count=10.
- MDU_WAIT, dmem_ready low for 3 cycles, mdu_done pulses during the freeze -> mem_wb_bubble=1 for 3 cycles, then release with no further MDU stall (done_seen honoured).
- mdu_done never arrives -> mdu_error=1 after 64 MDU_WAIT cycles. Pulse rst_n low mid-wait -> outputs at INIT values, mdu_error=0, RUN one cycle after release.
